// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked scratch RAM: FSM states, clog2, even parity.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

`ifdef RAM_BANKED_PARITY_EN
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/ram_bank.sv
// One WORDS x W bank: synchronous write, registered read (1 cycle), no backpressure.
// The caller guarantees that we and re are never asserted together.
module ram_bank #(
  parameter int W     = 8,
  parameter int WORDS = 4,
  parameter int WW    = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic          re,
  input  logic [WW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [WORDS];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // Storage has no reset; the top-level clear engine zeroes it after clr.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_banked.sv
// Banked scratch RAM with post-reset clear engine; parity option via RAM_BANKED_PARITY_EN.
// Reads return after 1 cycle with rd_valid; ready is low while clearing and req is then ignored.
module ram_banked
  import ram_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int BANKS  = 2,
  parameter  int WORDS  = 4,
  localparam int BW     = clog2(BANKS),
  localparam int WW     = clog2(WORDS),
  localparam int AW     = BW + WW
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              busy
`ifdef RAM_BANKED_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int SW = (BW > 0) ? BW : 1;
`ifdef RAM_BANKED_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  state_t        state_q, state_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] bank_sel;
  logic [SW-1:0] bank_sel_q, bank_sel_d;
  logic          rd_valid_q, rd_valid_d;
  logic [WW-1:0] word_sel;
  logic          clearing;
  logic          acc_wr;
  logic          acc_rd;
  logic [WW-1:0] bank_addr;
  logic [MW-1:0] bank_wdata;
  logic [MW-1:0] bank_rdata [BANKS];
  logic [MW-1:0] rd_word;

  assign word_sel = addr[WW-1:0];

  if (BW > 0) begin : g_sel
    assign bank_sel = addr[AW-1:WW];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  assign ready    = (state_q == IDLE) && !clr;
  assign busy     = !ready;
  assign clearing = (state_q == CLEAR);
  assign acc_wr   = req && ready && rw;
  assign acc_rd   = req && ready && !rw;

  // While clearing, every bank writes word cnt_q in parallel.
  assign bank_addr = clearing ? cnt_q : word_sel;

  always_comb begin
    bank_wdata = '0;
    if (!clearing) begin
`ifdef RAM_BANKED_PARITY_EN
      bank_wdata = {even_par(64'(data_in)), data_in};
`else
      bank_wdata = data_in;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    rd_valid_d = acc_rd;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + WW'(1);
        if (cnt_q == WW'(WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    if (acc_rd) bank_sel_d = bank_sel;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      bank_sel_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram_bank #(
      .W     (MW),
      .WORDS (WORDS),
      .WW    (WW)
    ) u_bank (
      .clk   (clk),
      .clr   (clr),
      .we    (clearing || (acc_wr && (bank_sel == SW'(b)))),
      .re    (acc_rd && (bank_sel == SW'(b))),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // Bank select registered at the read edge, so later addr changes don't disturb data_out.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_sel_q == SW'(b)) rd_word = bank_rdata[b];
    end
  end

  assign data_out = clr ? '0 : rd_word[DATA_W-1:0];
  assign rd_valid = rd_valid_q && !clr;

`ifdef RAM_BANKED_PARITY_EN
  assign parity_err = rd_valid &&
                      (even_par(64'(rd_word[DATA_W-1:0])) != rd_word[DATA_W]);
`endif

endmodule
